fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder stage of the 64-point FFT: the reader for the butterfly pipeline's writer.
//  The last bf16 stage emits bins in bit-reversed order; this block buffers each frame
//  in a 2-bank (ping-pong) register array and streams it out in natural order (X[0]..X[63]).
//  Sits between the final butterfly stage and the downstream consumer. valid/ready on both sides.
// PARAMETERS
//  WIDTH   13   bits per real/imag component (matches bf16 WIDTH)
//  LOG2N   6    log2 of frame length; N = 2**LOG2N = 64
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      input sample valid
//  in_ready     out  1      block can accept a sample this cycle
//  in_re        in   WIDTH  input real part, bit-reversed bin order
//  in_im        in   WIDTH  input imag part
//  out_valid    out  1      output sample valid
//  out_ready    in   1      consumer accepts output this cycle
//  out_re       out  WIDTH  output real part, natural bin order
//  out_im       out  WIDTH  output imag part
//  out_last     out  1      high with bin N-1 of each frame
// BEHAVIOUR
//  - Interface: one clock domain. rst_n is asynchronous, active-low; all state clears on assertion.
//  - Reset values: in_ready=1, out_valid=0, out_last=0, out_re=out_im=0, both banks empty.
//    Counters and bank pointers reset to 0.
//  - Input side: a sample is accepted when in_valid && in_ready.
//    - The n-th accepted sample of a frame (wr_cnt=n, 0..N-1) is written to address bitrev(n)
//      of bank wr_bank. bitrev reverses all LOG2N bits.
//    - On acceptance with wr_cnt==N-1: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
//    - in_ready = !full[wr_bank], registered state only. It does not depend on out_ready.
//  - Output side: the output register loads when load = full[rd_bank] && (!out_valid || out_ready).
//    - On load: out_re/out_im <= bank[rd_bank][rd_cnt], out_last <= (rd_cnt==N-1), out_valid <= 1.
//    - On load, rd_cnt increments. At N-1 it wraps to 0, clears full[rd_bank] and toggles rd_bank.
//    - If out_ready && out_valid && !load, then out_valid <= 0.
//    - While out_valid && !out_ready, the outputs hold stable.
//  - Latency: the 64th input is accepted at edge k, which sets full. The output register loads
//    bin 0 at edge k+1, so out_valid is high after k+1. Throughput is 1 sample/cycle sustained:
//    one bank fills while the other drains.
//  - Simultaneous events:
//    - Writer completing bank A and reader freeing bank B on the same edge: both flags update
//      independently; no lost frame.
//    - Writer finishing and reader starting the same bank cannot occur: the reader only loads
//      from a bank that is already full.
//  - Full/empty:
//    - Both banks full means in_ready=0, and input stalls until the reader wraps.
//    - Both banks empty means out_valid falls after the last accepted output.
//  - Partial frame: input gaps (in_valid low) are permitted; wr_cnt simply holds.
//  - Reset mid-frame discards both banks and any partial frame. There is no flush output.
//  - Storage: 2*N entries of 2*WIDTH bits, inferred as a register array. Read is combinational
//    into the output register. No arithmetic is performed; data passes through bit-exact.
// TESTING
//  1 Reset: drive rst_n=0 mid-stream, asynchronously and off-edge.
//    -> out_valid=0 and in_ready=1 immediately; the next frame starts at wr_cnt=0.
//  2 Reorder: in_re=n, in_im=-n for n=0..63, out_ready=1.
//    -> out_re sequence 0,32,16,48,8,40,...,63 (=bitrev(k)); out_last only on 63.
//    -> first out_valid 1 cycle after the 64th accept.
//  3 Back-to-back: 4 frames, in_valid=1, out_ready=1.
//    -> in_ready stays 1 throughout; 256 outputs with no bubbles after the first.
//    -> frame boundaries are marked by out_last.
//  4 Backpressure: out_ready=0 while 2 frames are sent.
//    -> in_ready drops after 128 accepts; out_re/out_im stay stable while stalled.
//    -> releasing out_ready drains 128 outputs in order, and in_ready returns to 1 after the first wrap.
//  5 Random gaps: 50% in_valid and 50% out_ready over 20 frames.
//    -> a scoreboard matches the bitrev model and no sample is dropped or duplicated.
//  6 Swap collision: time in_valid so the writer completes bank 1 on the same edge the reader
//    wraps bank 0.
//    -> both full flags are correct and the next frame streams without loss.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong reorder buffer that turns a bit-reversed 64-bin FFT frame
// into natural order. One bank fills from the butterfly pipeline while the other drains.
module fft_bitrev_reorder #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned LOG2N = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last
);

    localparam int unsigned N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    // Bank select is the MSB of the storage address.
    logic [2*WIDTH-1:0] mem [2*N];

    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             accept;
    logic             load;
    logic [2*WIDTH-1:0] rd_data;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = a[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    assign in_ready = !full[wr_bank];
    assign accept   = in_valid && in_ready;
    assign load     = full[rd_bank] && (!out_valid || out_ready);
    assign rd_data  = mem[{rd_bank, rd_cnt}];

    // Full flags: the reader only frees a full bank and the writer only fills an empty one,
    // so the clear and the set never target the same bank on one edge.
    always_comb begin
        full_nxt = full;
        if (load && (rd_cnt == LAST)) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (accept && (wr_cnt == LAST)) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Sample storage: scatter each accepted sample to its bit-reversed slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_bank, bitrev(wr_cnt)}] <= {in_re, in_im};
        end
    end

    // Writer side: frame counter and bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Bank occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    // Reader side: sequential read counter and bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (load) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == LAST) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Output register: loads on a free slot, holds while stalled, empties when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= (rd_cnt == LAST);
            out_re    <= rd_data[2*WIDTH-1:WIDTH];
            out_im    <= rd_data[WIDTH-1:0];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: directed phases with random data, scored against a
// frame-level model (output bin k of a frame equals accepted sample bitrev(k)).
module tb_fft_bitrev_reorder;

    localparam int W = 13;
    localparam int LG = 6;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         out_last;

    fft_bitrev_reorder #(.WIDTH(W), .LOG2N(LG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [W-1:0] frm_re[$];
    logic [W-1:0] frm_im[$];
    logic [W-1:0] exp_re[$];
    logic [W-1:0] exp_im[$];
    logic         exp_last[$];
    int cyc = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int frames = 0;
    int last_frame_cyc = -1;
    int first_valid_cyc = -1;
    int hs_first = -1;
    int hs_last = -1;

    function automatic int rev(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < LG; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        frm_re.delete();
        frm_im.delete();
        exp_re.delete();
        exp_im.delete();
        exp_last.delete();
        frames = 0;
    endtask

    // One clock: drive, observe at the falling edge, update model, step past rising edge.
    task automatic step(input logic iv, input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic ordy);
        in_valid = iv;
        in_re = re;
        in_im = im;
        out_ready = ordy;
        @(negedge clk);
        if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_re.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("out_re", 32'(out_re), 32'(exp_re[0]));
                chk("out_im", 32'(out_im), 32'(exp_im[0]));
                chk("out_last", 32'(out_last), 32'(exp_last[0]));
                if (out_ready) begin
                    void'(exp_re.pop_front());
                    void'(exp_im.pop_front());
                    void'(exp_last.pop_front());
                    out_cnt++;
                    if (hs_first < 0) hs_first = cyc;
                    hs_last = cyc;
                end
            end
        end
        if (in_valid && in_ready) begin
            frm_re.push_back(in_re);
            frm_im.push_back(in_im);
            acc_cnt++;
            if (frm_re.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    exp_re.push_back(frm_re[rev(k)]);
                    exp_im.push_back(frm_im[rev(k)]);
                    exp_last.push_back(k == N - 1);
                end
                frm_re.delete();
                frm_im.delete();
                frames++;
                last_frame_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int bound, input string tag);
        int i = 0;
        while ((exp_re.size() != 0 || out_valid) && i < bound) begin
            step(1'b0, '0, '0, 1'b1);
            i++;
        end
        chk(tag, 32'(exp_re.size()), 32'd0);
    endtask

    initial begin
        int a0;
        int o0;
        int i;
        logic saw_ready;

        // Power-on reset and reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_re", 32'(out_re), 32'd0);
        chk("rst_out_im", 32'(out_im), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: reset asserted mid-stream, off-edge
        for (int n = 0; n < N + 30; n++) step(1'b1, W'($urandom), W'($urandom), 1'b0);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_re", 32'(out_re), 32'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 2: ramp frame, latency of first output
        first_valid_cyc = -1;
        for (int n = 0; n < N; n++) step(1'b1, W'(n), W'(-n), 1'b1);
        drain(200, "ramp_drain");
        chk("ramp_latency", 32'(first_valid_cyc), 32'(last_frame_cyc + 2));

        // Test 3: four frames back-to-back
        hs_first = -1;
        o0 = out_cnt;
        a0 = acc_cnt;
        for (int n = 0; n < 4 * N; n++) begin
            step(1'b1, W'($urandom), W'($urandom), 1'b1);
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
        end
        drain(200, "b2b_drain");
        chk("b2b_accepts", 32'(acc_cnt - a0), 32'(4 * N));
        chk("b2b_outputs", 32'(out_cnt - o0), 32'(4 * N));
        chk("b2b_no_bubble", 32'(hs_last - hs_first), 32'(4 * N - 1));

        // Test 4: backpressure with two frames
        a0 = acc_cnt;
        o0 = out_cnt;
        for (int n = 0; n < 2 * N + 8; n++) step(1'b1, W'($urandom), W'($urandom), 1'b0);
        chk("bp_accepts", 32'(acc_cnt - a0), 32'(2 * N));
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        step(1'b0, '0, '0, 1'b1);
        chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        saw_ready = 1'b0;
        for (int n = 0; n < 70; n++) step(1'b0, '0, '0, 1'b1);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        drain(200, "bp_drain");
        chk("bp_outputs", 32'(out_cnt - o0), 32'(2 * N));

        // Test 5: random gaps on both sides over 20 frames
        a0 = acc_cnt;
        o0 = out_cnt;
        i = 0;
        while ((acc_cnt - a0) < 20 * N && i < 20000) begin
            step(1'($urandom % 2), W'($urandom), W'($urandom), 1'($urandom % 2));
            i++;
        end
        chk("rand_accept_bound", 32'(acc_cnt - a0), 32'(20 * N));
        drain(2000, "rand_drain");
        chk("rand_outputs", 32'(out_cnt - o0), 32'(20 * N));

        // Test 6: 27 frames so far, so the next frame lands in bank 1; streaming three
        // frames makes the bank-1 completion coincide with the bank-0 drain wrap.
        chk("swap_bank_parity", 32'(frames % 2), 32'd1);
        hs_first = -1;
        o0 = out_cnt;
        for (int n = 0; n < 3 * N; n++) begin
            step(1'b1, W'($urandom), W'($urandom), 1'b1);
            chk("swap_in_ready", 32'(in_ready), 32'd1);
        end
        drain(200, "swap_drain");
        chk("swap_outputs", 32'(out_cnt - o0), 32'(3 * N));
        chk("swap_no_bubble", 32'(hs_last - hs_first), 32'(3 * N - 1));
        chk("final_out_valid", 32'(out_valid), 32'd0);
        chk("final_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
